// File: rtl/tdm_demux_1to2.sv
// rtl/tdm_demux_1to2.sv - 1:2 serial TDM demultiplexer with framing and optional parity (TDM_DEMUX_PARITY_EN).
module tdm_demux_1to2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             frame_err,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef TDM_DEMUX_PARITY_EN
    // The complete word must survive into the parity-bit cycle.
    localparam int SW = WIDTH;
    typedef enum logic [2:0] {IDLE, CH0, CH1, CH0_P, CH1_P} state_t;
`else
    localparam int SW = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   shift;
    logic [WIDTH-1:0] word_next;

    assign word_next = {shift[WIDTH-2:0], din};

`ifndef TDM_DEMUX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            y0        <= '0;
            y1        <= '0;
            y0_valid  <= 1'b0;
            y1_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            y0_valid  <= 1'b0;
            y1_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err   <= 1'b0;
`endif
            if (din_valid) begin
                if (frame_sync) begin
                    // A sync always restarts channel 0; mid-frame it also flags an error.
                    frame_err <= (state != IDLE);
                    shift     <= SW'(din);
                    cnt       <= CW'(1);
                    state     <= CH0;
                end else begin
                    case (state)
                        IDLE: ;
                        CH0, CH1: begin
                            shift <= word_next[SW-1:0];
                            if (cnt == LAST) begin
                                cnt <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                                state <= (state == CH0) ? CH0_P : CH1_P;
`else
                                if (state == CH0) begin
                                    y0       <= word_next;
                                    y0_valid <= 1'b1;
                                    state    <= CH1;
                                end else begin
                                    y1       <= word_next;
                                    y1_valid <= 1'b1;
                                    state    <= IDLE;
                                end
`endif
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
`ifdef TDM_DEMUX_PARITY_EN
                        CH0_P, CH1_P: begin
                            if (^{shift, din}) begin
                                par_err <= 1'b1;
                            end else if (state == CH0_P) begin
                                y0       <= shift;
                                y0_valid <= 1'b1;
                            end else begin
                                y1       <= shift;
                                y1_valid <= 1'b1;
                            end
                            state <= (state == CH0_P) ? CH1 : IDLE;
                        end
`endif
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/tdm_demux_1to2.md
TDM_DEMUX_1TO2 -- requirements
Module: tdm_demux_1to2

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, bits per channel slot (legal range 2..16).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: din  input  1  serial TDM bit stream; channel 0 slot then channel 1 slot, MSB first.
REQ-005 SHALL provide port: din_valid  input  1  qualifies din and frame_sync for the current cycle.
REQ-006 SHALL provide port: frame_sync  input  1  marks the first bit of a channel 0 slot; sampled only when din_valid=1.
REQ-007 SHALL provide port: y0  output  WIDTH  last good channel 0 word, registered.
REQ-008 SHALL provide port: y1  output  WIDTH  last good channel 1 word, registered.
REQ-009 SHALL provide port: y0_valid  output  1  one-cycle pulse when y0 is updated.
REQ-010 SHALL provide port: y1_valid  output  1  one-cycle pulse when y1 is updated.
REQ-011 SHALL provide port: frame_err  output  1  one-cycle pulse on a framing violation.
REQ-012 SHALL provide port: par_err  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-013 SHALL implement FSM states IDLE, CH0, CH1 (plus CH0_P, CH1_P when parity is compiled in), with a bit counter 0..WIDTH-1.
REQ-014 SHALL advance state, counter, and shift register only on clk edges where din_valid=1; din_valid=0 holds all state indefinitely.
REQ-015 SHALL, in IDLE, discard valid bits with frame_sync=0 without asserting any output.
REQ-016 SHALL, in IDLE, treat a valid bit with frame_sync=1 as bit WIDTH-1 of channel 0, then enter CH0 with counter=1.
REQ-017 SHALL, on the WIDTH-th valid bit in CH0, load y0 and pulse y0_valid in the next cycle, then go to CH1 (or CH0_P).
REQ-018 SHALL, on the WIDTH-th valid bit in CH1, load y1 and pulse y1_valid in the next cycle, then return to IDLE (or go to CH1_P).
REQ-019 SHALL give a latency of exactly one clk from the sampling edge of the last slot bit to the corresponding yN/yN_valid update.
REQ-020 SHALL treat a valid frame_sync=1 in any state other than IDLE as a framing violation: pulse frame_err in the next cycle, drop the partial word, take that bit as channel 0 bit WIDTH-1, and enter CH0 with counter=1.
REQ-021 SHALL hold y0 and y1 between updates; yN_valid and the error outputs SHALL never exceed one cycle per event.
REQ-022 SHALL allow y0_valid and frame_err in the same cycle only if they come from different edges; for a single sampled bit, the error path takes priority and no word is emitted.

Reset
REQ-023 SHALL, while rst_n=0, immediately drive y0, y1, y0_valid, y1_valid, frame_err, and par_err to 0, force the FSM to IDLE, and clear the counter and shift register, independent of clk.
REQ-024 SHALL, when reset is asserted mid-slot, discard the partial word; after release, the FSM SHALL wait in IDLE for frame_sync.

Configuration
REQ-025 SHALL use macro TDM_DEMUX_PARITY_EN to compile in parity checking; when it is undefined, slots are WIDTH bits and par_err is tied 0.
REQ-026 SHALL, with TDM_DEMUX_PARITY_EN defined, expect one even-parity bit after each slot (states CH0_P, CH1_P).
REQ-027 SHALL, on a parity match, update yN/yN_valid one cycle after the parity bit is sampled.
REQ-028 SHALL, on a parity mismatch, pulse par_err, hold yN, suppress yN_valid, and continue to the next state normally.
REQ-029 SHALL treat frame_sync on a parity bit as REQ-020.

Verification
REQ-030 SHALL cover: WIDTH=4, sync with bits 1010 then 0110, din_valid always high -> y0=4'hA with y0_valid one cycle after bit 4; y1=4'h6 with y1_valid one cycle after bit 8; FSM back in IDLE.
REQ-031 SHALL cover: the same frame with din_valid=0 gaps of 1..3 cycles between bits -> identical y0/y1 values, one pulse each, no frame_err.
REQ-032 SHALL cover: valid bits 1,1,0 without sync in IDLE -> no outputs; then a normal frame 0011/1100 -> y0=4'h3, y1=4'hC.
REQ-033 SHALL cover: frame_sync reasserted on channel 0 bit 3 -> frame_err one cycle, no y0_valid, next 4 bits 1111 (sync on the first) -> y0=4'hF.
REQ-034 SHALL cover: rst_n driven low mid-CH1 between clk edges -> all outputs 0 immediately; after release, bits without sync are ignored.
REQ-035 SHALL cover, with TDM_DEMUX_PARITY_EN: ch0 1010 p=0 and ch1 0111 p=0 -> y0=4'hA valid; par_err pulse on ch1; y1 unchanged; no y1_valid.
